// File: rtl/line_pulse_rx.sv
// Pulse-width monitor for an asynchronous single-bit wire. Each completed high or low
// pulse is measured in clk cycles and presented as an event in a one-entry valid/ready slot.
module line_pulse_rx #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned MIN_PULSE   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             line_i,
    input  logic             en,
    input  logic             clr,
    output logic             line_sync,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic             evt_level,
    output logic [CNT_W-1:0] evt_width,
    output logic             evt_sat,
    output logic [CNT_W-1:0] glitch_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam logic [CNT_W-1:0] WMax = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] WOne = CNT_W'(1);
    localparam logic [CNT_W-1:0] MinW = CNT_W'(MIN_PULSE);

    typedef enum logic [1:0] {StIdle, StArmed, StMeas} state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   line_sync_d;
    state_e                 state_q;
    logic [CNT_W-1:0]       w_q;

    logic edge_det;
    logic meas_edge;
    logic glitch;
    logic offer;
    logic xfer;

    assign line_sync = sync_q[SYNC_STAGES-1];
    assign edge_det  = line_sync ^ line_sync_d;
    assign meas_edge = (state_q == StMeas) && en && edge_det;
    assign glitch    = meas_edge && (w_q < MinW);
    assign offer     = meas_edge && !glitch;
    assign xfer      = evt_valid && evt_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '0;
            line_sync_d <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], line_i};
            line_sync_d <= line_sync;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            w_q        <= '0;
            evt_valid  <= 1'b0;
            evt_level  <= 1'b0;
            evt_width  <= '0;
            evt_sat    <= 1'b0;
            glitch_cnt <= '0;
            drop_cnt   <= '0;
        end else begin
            // The level present before the first edge has unknown length, so ARMED
            // only starts the count and never reports.
            unique case (state_q)
                StIdle: begin
                    w_q <= '0;
                    if (en) state_q <= StArmed;
                end
                StArmed: begin
                    if (!en) begin
                        state_q <= StIdle;
                    end else if (edge_det) begin
                        w_q     <= WOne;
                        state_q <= StMeas;
                    end
                end
                StMeas: begin
                    if (!en) begin
                        state_q <= StIdle;
                        w_q     <= '0;
                    end else if (edge_det) begin
                        w_q <= WOne;
                    end else if (w_q != WMax) begin
                        w_q <= w_q + WOne;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    w_q     <= '0;
                end
            endcase

            // A transfer in the same cycle frees the slot for the new offer.
            if (offer && (!evt_valid || xfer)) begin
                evt_valid <= 1'b1;
                evt_level <= line_sync_d;
                evt_width <= w_q;
                evt_sat   <= (w_q == WMax);
            end else if (xfer) begin
                evt_valid <= 1'b0;
            end

            if (clr) begin
                glitch_cnt <= '0;
            end else if (glitch && (glitch_cnt != WMax)) begin
                glitch_cnt <= glitch_cnt + WOne;
            end

            if (clr) begin
                drop_cnt <= '0;
            end else if (offer && evt_valid && !xfer && (drop_cnt != WMax)) begin
                drop_cnt <= drop_cnt + WOne;
            end
        end
    end

endmodule

// File: tb/tb_line_pulse_rx.sv
// Directed bench for line_pulse_rx: a CNT_W=16 instance and a CNT_W=4 instance share
// all stimulus; the narrow one is only examined for width saturation.
module tb_line_pulse_rx;

    localparam int unsigned S = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        line_i;
    logic        en;
    logic        clr;
    logic        evt_ready;

    logic        line_sync;
    logic        evt_valid;
    logic        evt_level;
    logic [15:0] evt_width;
    logic        evt_sat;
    logic [15:0] glitch_cnt;
    logic [15:0] drop_cnt;

    logic        s_line_sync;
    logic        s_evt_valid;
    logic        s_evt_level;
    logic [3:0]  s_evt_width;
    logic        s_evt_sat;
    logic [3:0]  s_glitch_cnt;
    logic [3:0]  s_drop_cnt;

    int checks = 0;
    int errors = 0;
    logic [16:0] evq[$];

    line_pulse_rx #(.SYNC_STAGES(S), .CNT_W(16), .MIN_PULSE(2)) dut (
        .clk(clk), .rst_n(rst_n), .line_i(line_i), .en(en), .clr(clr),
        .line_sync(line_sync), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_level(evt_level), .evt_width(evt_width), .evt_sat(evt_sat),
        .glitch_cnt(glitch_cnt), .drop_cnt(drop_cnt)
    );

    line_pulse_rx #(.SYNC_STAGES(S), .CNT_W(4), .MIN_PULSE(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .line_i(line_i), .en(en), .clr(clr),
        .line_sync(s_line_sync), .evt_valid(s_evt_valid), .evt_ready(evt_ready),
        .evt_level(s_evt_level), .evt_width(s_evt_width), .evt_sat(s_evt_sat),
        .glitch_cnt(s_glitch_cnt), .drop_cnt(s_drop_cnt)
    );

    always #5 clk = ~clk;

    // Record every transferred event of the wide instance as {level, width}.
    always @(negedge clk) begin
        if (rst_n && evt_valid && evt_ready) evq.push_back({evt_level, evt_width});
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; line_i = 1'b0; en = 1'b0; clr = 1'b0; evt_ready = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; line_i = 1'b1; en = 1'b0; clr = 1'b0; evt_ready = 1'b0;
        tick(3);
        checks++; if (line_sync !== 1'b0) begin errors++; $display("FAIL rst_line_sync: got %0b expected 0", line_sync); end
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL rst_evt_valid: got %0b expected 0", evt_valid); end
        checks++; if (evt_level !== 1'b0) begin errors++; $display("FAIL rst_evt_level: got %0b expected 0", evt_level); end
        checks++; if (evt_width !== 16'd0) begin errors++; $display("FAIL rst_evt_width: got %0d expected 0", evt_width); end
        checks++; if (evt_sat !== 1'b0) begin errors++; $display("FAIL rst_evt_sat: got %0b expected 0", evt_sat); end
        checks++; if (glitch_cnt !== 16'd0) begin errors++; $display("FAIL rst_glitch_cnt: got %0d expected 0", glitch_cnt); end
        checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL rst_drop_cnt: got %0d expected 0", drop_cnt); end
        rst_n = 1'b1;
        tick(S - 1);
        checks++; if (line_sync !== 1'b0) begin errors++; $display("FAIL sync_early: got %0b expected 0", line_sync); end
        tick(1);
        checks++; if (line_sync !== 1'b1) begin errors++; $display("FAIL sync_latency: got %0b expected 1", line_sync); end
    endtask

    task automatic test_basic_pulse();
        int lat;
        do_reset();
        evt_ready = 1'b1; en = 1'b1;
        tick(2);
        evq.delete();
        line_i = 1'b1;
        tick(10);
        line_i = 1'b0;
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            tick(1);
            if (evt_valid) begin
                lat = i;
                break;
            end
        end
        checks++; if (lat != S + 1) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", lat, S + 1); end
        checks++; if (evt_level !== 1'b1) begin errors++; $display("FAIL basic_level: got %0b expected 1", evt_level); end
        checks++; if (evt_width !== 16'd10) begin errors++; $display("FAIL basic_width: got %0d expected 10", evt_width); end
        checks++; if (evt_sat !== 1'b0) begin errors++; $display("FAIL basic_sat: got %0b expected 0", evt_sat); end
        tick(1);
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL basic_one_cycle: got %0b expected 0", evt_valid); end
        tick(3);
        checks++; if (evq.size() != 1) begin errors++; $display("FAIL basic_event_count: got %0d expected 1", evq.size()); end
    endtask

    task automatic test_glitch();
        logic [16:0] exp_ev [3];
        logic [16:0] got;
        exp_ev = '{17'h1_0005, 17'h0_0004, 17'h0_0006};
        do_reset();
        evt_ready = 1'b1; en = 1'b1;
        tick(2);
        evq.delete();
        line_i = 1'b1; tick(5);
        line_i = 1'b0; tick(4);
        line_i = 1'b1; tick(1);
        line_i = 1'b0; tick(6);
        line_i = 1'b1; tick(6);
        checks++; if (glitch_cnt !== 16'd1) begin errors++; $display("FAIL glitch_cnt: got %0d expected 1", glitch_cnt); end
        checks++; if (evq.size() != 3) begin errors++; $display("FAIL glitch_event_count: got %0d expected 3", evq.size()); end
        for (int i = 0; i < 3; i++) begin
            got = (i < evq.size()) ? evq[i] : 17'h1_ffff;
            checks++;
            if (got !== exp_ev[i]) begin
                errors++;
                $display("FAIL glitch_event%0d: got level %0b width %0d expected level %0b width %0d",
                         i, got[16], got[15:0], exp_ev[i][16], exp_ev[i][15:0]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [16:0] got;
        do_reset();
        en = 1'b1; evt_ready = 1'b0;
        tick(2);
        evq.delete();
        line_i = 1'b1; tick(5);
        line_i = 1'b0; tick(6);
        line_i = 1'b1; tick(7);
        line_i = 1'b0; tick(5);
        checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %0b expected 1", evt_valid); end
        checks++; if (evt_level !== 1'b1) begin errors++; $display("FAIL bp_level: got %0b expected 1", evt_level); end
        checks++; if (evt_width !== 16'd5) begin errors++; $display("FAIL bp_width_held: got %0d expected 5", evt_width); end
        checks++; if (drop_cnt !== 16'd2) begin errors++; $display("FAIL bp_drop_cnt: got %0d expected 2", drop_cnt); end
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got %0b expected 0", evt_valid); end
        got = (evq.size() > 0) ? evq[0] : 17'h1_ffff;
        checks++; if (got !== 17'h1_0005) begin errors++; $display("FAIL bp_released_event: got %0h expected 10005", got); end
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL bp_clr: got %0d expected 0", drop_cnt); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        en = 1'b1; evt_ready = 1'b0;
        tick(2);
        evq.delete();
        line_i = 1'b1; tick(5);
        line_i = 1'b0; tick(3);
        line_i = 1'b1;
        checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL b2b_first_valid: got %0b expected 1", evt_valid); end
        checks++; if (evt_width !== 16'd5) begin errors++; $display("FAIL b2b_first_width: got %0d expected 5", evt_width); end
        // Raise ready so the transfer lands on the same edge as the low-pulse offer.
        tick(2);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_kept: got %0b expected 1", evt_valid); end
        checks++; if (evt_width !== 16'd3) begin errors++; $display("FAIL b2b_new_width: got %0d expected 3", evt_width); end
        checks++; if (evt_level !== 1'b0) begin errors++; $display("FAIL b2b_new_level: got %0b expected 0", evt_level); end
        checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL b2b_drop_cnt: got %0d expected 0", drop_cnt); end
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %0b expected 0", evt_valid); end
        checks++; if (evq.size() != 2) begin errors++; $display("FAIL b2b_event_count: got %0d expected 2", evq.size()); end
    endtask

    task automatic test_saturation_abort();
        do_reset();
        en = 1'b1; evt_ready = 1'b1;
        tick(2);
        line_i = 1'b1; tick(40);
        line_i = 1'b0; tick(S + 1);
        checks++; if (s_evt_valid !== 1'b1) begin errors++; $display("FAIL sat_valid: got %0b expected 1", s_evt_valid); end
        checks++; if (s_evt_width !== 4'd15) begin errors++; $display("FAIL sat_width: got %0d expected 15", s_evt_width); end
        checks++; if (s_evt_sat !== 1'b1) begin errors++; $display("FAIL sat_flag: got %0b expected 1", s_evt_sat); end
        checks++; if (evt_width !== 16'd40) begin errors++; $display("FAIL wide_width: got %0d expected 40", evt_width); end
        checks++; if (evt_sat !== 1'b0) begin errors++; $display("FAIL wide_sat: got %0b expected 0", evt_sat); end

        tick(4);
        line_i = 1'b1; tick(5);
        evq.delete();
        en = 1'b0; tick(3);
        line_i = 1'b0; tick(8);
        checks++; if (evq.size() != 0) begin errors++; $display("FAIL abort_no_event: got %0d expected 0", evq.size()); end
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %0b expected 0", evt_valid); end

        en = 1'b1; evt_ready = 1'b0;
        tick(2);
        line_i = 1'b1; tick(4);
        line_i = 1'b0; tick(S + 2);
        checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL pend_valid: got %0b expected 1", evt_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL rst_clears_slot: got %0b expected 0", evt_valid); end
        checks++; if (evt_width !== 16'd0) begin errors++; $display("FAIL rst_clears_width: got %0d expected 0", evt_width); end
        checks++; if (s_evt_valid !== 1'b0) begin errors++; $display("FAIL rst_clears_slot_s: got %0b expected 0", s_evt_valid); end
        tick(1);
        rst_n = 1'b1;
        tick(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic_pulse();
        test_glitch();
        test_backpressure();
        test_back_to_back();
        test_saturation_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
